// File: rtl/fc_rx_credit_buffer.sv
// Receiver-side flow-control credit buffer for one credit type: stores TLP words, tracks credit counters, issues InitFC/UpdateFC.
// Optional periodic UpdateFC resend timer enabled by defining FC_UPDATE_TIMER_EN.
module fc_rx_credit_buffer #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned CREDIT_WIDTH  = 8,
    parameter int unsigned INIT_REPEATS  = 2,
    parameter int unsigned UPDATE_PERIOD = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    link_up,
    input  logic                    tlp_valid,
    input  logic [DATA_WIDTH-1:0]   tlp_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    empty,
    output logic                    fc_valid,
    output logic                    fc_type,
    output logic [CREDIT_WIDTH-1:0] fc_credit_limit,
    input  logic                    fc_ack,
    output logic [CREDIT_WIDTH-1:0] credits_received,
    output logic [CREDIT_WIDTH-1:0] credits_allocated,
    output logic                    init_done,
    output logic                    overflow_err
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned INIT_W = $clog2(INIT_REPEATS + 1);

    if (FIFO_DEPTH == 0 || INIT_REPEATS == 0 || UPDATE_PERIOD < 2) begin : g_param_check
        $error("fc_rx_credit_buffer: illegal parameter value");
    end

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [INIT_W-1:0]     init_cnt;
    logic                  update_pending;

    logic                  wr_acc_c;
    logic                  ovf_c;
    logic                  pop_c;
    logic                  xfer_c;
    logic                  issue_c;
    logic                  timer_exp_c;
    logic [CNT_W-1:0]      count_nxt_c;

    // Per-cycle write/pop/handshake qualifiers; the full check uses the pre-cycle count.
    always_comb begin
        wr_acc_c    = (state == S_RUN) && link_up && tlp_valid && (count < CNT_W'(FIFO_DEPTH));
        ovf_c       = (state == S_RUN) && link_up && tlp_valid && (count == CNT_W'(FIFO_DEPTH));
        pop_c       = link_up && rd_en && !empty;
        xfer_c      = fc_valid && fc_ack;
        issue_c     = (state == S_RUN) && !fc_valid && (update_pending || timer_exp_c);
        count_nxt_c = count;
        if (wr_acc_c && !pop_c) begin
            count_nxt_c = count + CNT_W'(1);
        end else if (!wr_acc_c && pop_c) begin
            count_nxt_c = count - CNT_W'(1);
        end
    end

`ifdef FC_UPDATE_TIMER_EN
    localparam int unsigned TMR_W = $clog2(UPDATE_PERIOD);

    logic [TMR_W-1:0] upd_timer;

    assign timer_exp_c = (upd_timer == TMR_W'(UPDATE_PERIOD - 1));

    // Counts RUN cycles since the last transfer; saturates until the resend is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_timer <= '0;
        end else if (!link_up || state != S_RUN || xfer_c) begin
            upd_timer <= '0;
        end else if (!timer_exp_c) begin
            upd_timer <= upd_timer + TMR_W'(1);
        end
    end
`else
    assign timer_exp_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem[wr_ptr] <= tlp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            init_cnt          <= '0;
            update_pending    <= 1'b0;
            data_out          <= '0;
            empty             <= 1'b1;
            fc_valid          <= 1'b0;
            fc_type           <= 1'b0;
            fc_credit_limit   <= '0;
            credits_received  <= '0;
            credits_allocated <= '0;
            init_done         <= 1'b0;
            overflow_err      <= 1'b0;
        end else if (!link_up) begin
            // Link down flushes everything except the last popped word.
            state             <= S_IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            init_cnt          <= '0;
            update_pending    <= 1'b0;
            empty             <= 1'b1;
            fc_valid          <= 1'b0;
            fc_type           <= 1'b0;
            fc_credit_limit   <= '0;
            credits_received  <= '0;
            credits_allocated <= '0;
            init_done         <= 1'b0;
            overflow_err      <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr           <= wr_ptr + PTR_W'(1);
                credits_received <= credits_received + CREDIT_WIDTH'(1);
            end
            if (ovf_c) begin
                overflow_err <= 1'b1;
            end
            if (pop_c) begin
                data_out          <= mem[rd_ptr];
                rd_ptr            <= rd_ptr + PTR_W'(1);
                credits_allocated <= credits_allocated + CREDIT_WIDTH'(1);
            end
            count <= count_nxt_c;
            empty <= (count_nxt_c == '0);

            case (state)
                S_IDLE: begin
                    state             <= S_INIT;
                    init_cnt          <= '0;
                    credits_allocated <= CREDIT_WIDTH'(FIFO_DEPTH);
                    fc_valid          <= 1'b1;
                    fc_type           <= 1'b0;
                    fc_credit_limit   <= CREDIT_WIDTH'(FIFO_DEPTH);
                end
                S_INIT: begin
                    // Re-raise InitFC after the mandatory idle cycle following each transfer.
                    if (xfer_c) begin
                        fc_valid <= 1'b0;
                        if (init_cnt == INIT_W'(INIT_REPEATS - 1)) begin
                            state     <= S_RUN;
                            init_done <= 1'b1;
                        end else begin
                            init_cnt <= init_cnt + INIT_W'(1);
                        end
                    end else if (!fc_valid) begin
                        fc_valid <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (xfer_c) begin
                        fc_valid <= 1'b0;
                    end else if (issue_c) begin
                        fc_valid        <= 1'b1;
                        fc_type         <= 1'b1;
                        fc_credit_limit <= credits_allocated;
                    end
                    update_pending <= pop_c || (update_pending && !issue_c);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_rx_credit_buffer.sv
// Self-checking bench for fc_rx_credit_buffer: queue-based reference model compared every cycle plus directed literal checks.
module tb_fc_rx_credit_buffer;
    logic       clk;
    logic       rst_n;
    logic       link_up;
    logic       tlp_valid;
    logic [7:0] tlp_data;
    logic       rd_en;
    logic [7:0] data_out;
    logic       empty;
    logic       fc_valid;
    logic       fc_type;
    logic [7:0] fc_credit_limit;
    logic       fc_ack;
    logic [7:0] credits_received;
    logic [7:0] credits_allocated;
    logic       init_done;
    logic       overflow_err;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 0;
    bit auto_ack = 0;

    fc_rx_credit_buffer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .link_up           (link_up),
        .tlp_valid         (tlp_valid),
        .tlp_data          (tlp_data),
        .rd_en             (rd_en),
        .data_out          (data_out),
        .empty             (empty),
        .fc_valid          (fc_valid),
        .fc_type           (fc_type),
        .fc_credit_limit   (fc_credit_limit),
        .fc_ack            (fc_ack),
        .credits_received  (credits_received),
        .credits_allocated (credits_allocated),
        .init_done         (init_done),
        .overflow_err      (overflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phase 0 idle, 1 init, 2 run; buffer as a queue, counters as mod-256 integers.
    logic [7:0] q[$];
    int         m_phase = 0;
    int         m_rx = 0;
    int         m_alloc = 0;
    int         m_lim = 0;
    int         m_init_xfers = 0;
    bit         m_fcv = 0;
    bit         m_fct = 0;
    bit         m_pend = 0;
    bit         m_ovf = 0;
    logic [7:0] m_dout = 8'h00;
    bit         mdl_pop, mdl_full, mdl_xfer, mdl_issue;
    int         mdl_alloc_before;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !link_up) begin
            q.delete();
            m_phase = 0; m_rx = 0; m_alloc = 0; m_lim = 0; m_init_xfers = 0;
            m_fcv = 0; m_fct = 0; m_pend = 0; m_ovf = 0;
            if (!rst_n) m_dout = 8'h00;
        end else begin
            mdl_full         = (q.size() == 16);
            mdl_pop          = rd_en && (q.size() != 0);
            mdl_xfer         = m_fcv && fc_ack;
            mdl_alloc_before = m_alloc;
            if (mdl_pop) begin
                m_dout  = q.pop_front();
                m_alloc = (m_alloc + 1) % 256;
            end
            if (m_phase == 2 && tlp_valid) begin
                if (mdl_full) m_ovf = 1;
                else begin
                    q.push_back(tlp_data);
                    m_rx = (m_rx + 1) % 256;
                end
            end
            if (m_phase == 0) begin
                m_phase = 1; m_alloc = 16; m_fcv = 1; m_fct = 0; m_lim = 16; m_init_xfers = 0;
            end else if (m_phase == 1) begin
                if (mdl_xfer) begin
                    m_fcv = 0;
                    m_init_xfers++;
                    if (m_init_xfers == 2) m_phase = 2;
                end else if (!m_fcv) m_fcv = 1;
            end else begin
                mdl_issue = !m_fcv && m_pend;
                if (mdl_xfer) m_fcv = 0;
                else if (mdl_issue) begin
                    m_fcv = 1; m_fct = 1; m_lim = mdl_alloc_before;
                end
                m_pend = mdl_pop || (m_pend && !mdl_issue);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m.data_out", 32'(data_out), 32'(m_dout));
            chk("m.empty", 32'(empty), 32'(q.size() == 0));
            chk("m.fc_valid", 32'(fc_valid), 32'(m_fcv));
            if (m_fcv) begin
                chk("m.fc_type", 32'(fc_type), 32'(m_fct));
                chk("m.fc_limit", 32'(fc_credit_limit), 32'(m_lim));
            end
            chk("m.credits_received", 32'(credits_received), 32'(m_rx));
            chk("m.credits_allocated", 32'(credits_allocated), 32'(m_alloc));
            chk("m.init_done", 32'(init_done), 32'(m_phase == 2));
            chk("m.overflow_err", 32'(overflow_err), 32'(m_ovf));
        end
    end

    task automatic tick();
        @(negedge clk);
        if (auto_ack) fc_ack = fc_valid;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!init_done && n < 30) begin
            tick();
            n++;
        end
        chk(name, 32'(init_done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; link_up = 1'b0; tlp_valid = 1'b0; tlp_data = 8'h00; rd_en = 1'b0; fc_ack = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        chk("rst.fc_valid", 32'(fc_valid), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.credits_allocated", 32'(credits_allocated), 32'd0);
        chk("rst.data_out", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // Link init: two acknowledged InitFC with limit 16.
        link_up = 1'b1;
        tick();
        chk("init1.fc_valid", 32'(fc_valid), 32'd1);
        chk("init1.fc_type", 32'(fc_type), 32'd0);
        chk("init1.limit", 32'(fc_credit_limit), 32'd16);
        fc_ack = 1'b1; tick(); fc_ack = 1'b0;
        chk("init.gap", 32'(fc_valid), 32'd0);
        tick();
        chk("init2.limit", 32'(fc_credit_limit), 32'd16);
        fc_ack = 1'b1; tick(); fc_ack = 1'b0;
        chk("init.done", 32'(init_done), 32'd1);
        chk("init.alloc", 32'(credits_allocated), 32'd16);

        // Fill the buffer, then overflow.
        for (int i = 0; i < 16; i++) begin
            tlp_valid = 1'b1; tlp_data = 8'(i); tick();
        end
        chk("fill.rx", 32'(credits_received), 32'd16);
        chk("fill.ovf", 32'(overflow_err), 32'd0);
        tlp_data = 8'hAA; tick(); tlp_valid = 1'b0;
        chk("ovf.err", 32'(overflow_err), 32'd1);
        chk("ovf.rx", 32'(credits_received), 32'd16);

        // Pop 4 with ack held low: one UpdateFC limit 17, then 20 after the ack.
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; tick();
            chk("pop.data", 32'(data_out), 32'(i));
        end
        rd_en = 1'b0;
        repeat (3) tick();
        chk("upd1.valid", 32'(fc_valid), 32'd1);
        chk("upd1.type", 32'(fc_type), 32'd1);
        chk("upd1.limit", 32'(fc_credit_limit), 32'd17);
        fc_ack = 1'b1; tick(); fc_ack = 1'b0;
        chk("upd.gap", 32'(fc_valid), 32'd0);
        tick();
        chk("upd2.valid", 32'(fc_valid), 32'd1);
        chk("upd2.limit", 32'(fc_credit_limit), 32'd20);
        fc_ack = 1'b1; tick(); fc_ack = 1'b0;

        // Simultaneous write and pop at count 8, then drain and pop when empty.
        auto_ack = 1;
        for (int i = 4; i < 8; i++) begin
            rd_en = 1'b1; tick();
            chk("pop2.data", 32'(data_out), 32'(i));
        end
        tlp_valid = 1'b1; tlp_data = 8'h55; tick(); tlp_valid = 1'b0;
        chk("wp.data", 32'(data_out), 32'h08);
        chk("wp.rx", 32'(credits_received), 32'd17);
        chk("wp.alloc", 32'(credits_allocated), 32'd25);
        for (int i = 9; i < 16; i++) begin
            tick();
            chk("drain.data", 32'(data_out), 32'(i));
        end
        chk("drain.not_empty", 32'(empty), 32'd0);
        tick();
        chk("drain.last", 32'(data_out), 32'h55);
        chk("drain.empty", 32'(empty), 32'd1);
        tick();
        rd_en = 1'b0;
        chk("empty_pop.data", 32'(data_out), 32'h55);
        chk("empty_pop.alloc", 32'(credits_allocated), 32'd33);

        // Link drop clears the sticky error; re-init with tlp_valid ignored during INIT.
        link_up = 1'b0; tick();
        chk("down.ovf", 32'(overflow_err), 32'd0);
        chk("down.alloc", 32'(credits_allocated), 32'd0);
        chk("down.data_hold", 32'(data_out), 32'h55);
        link_up = 1'b1; tlp_valid = 1'b1; tlp_data = 8'h77;
        wait_init("reinit.done");
        tlp_valid = 1'b0;
        chk("reinit.rx", 32'(credits_received), 32'd0);

        // 250 write/pop pairs: counters wrap modulo 256.
        tlp_valid = 1'b1; tlp_data = 8'h00; tick();
        for (int i = 1; i < 250; i++) begin
            rd_en = 1'b1; tlp_data = 8'(i); tick();
        end
        tlp_valid = 1'b0; tick(); rd_en = 1'b0;
        chk("pairs.last", 32'(data_out), 32'd249);
        chk("pairs.rx", 32'(credits_received), 32'd250);
        chk("pairs.alloc", 32'(credits_allocated), 32'd10);
        chk("pairs.ovf", 32'(overflow_err), 32'd0);
        repeat (4) tick();

        // Link drop with 5 words buffered and an UpdateFC outstanding.
        auto_ack = 0; fc_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tlp_valid = 1'b1; tlp_data = 8'(8'hA0 + i); tick();
        end
        tlp_valid = 1'b0; rd_en = 1'b1; tick(); rd_en = 1'b0;
        repeat (2) tick();
        chk("out.valid", 32'(fc_valid), 32'd1);
        chk("out.limit", 32'(fc_credit_limit), 32'd11);
        link_up = 1'b0; tick();
        chk("drop.fc_valid", 32'(fc_valid), 32'd0);
        chk("drop.rx", 32'(credits_received), 32'd0);
        chk("drop.empty", 32'(empty), 32'd1);
        chk("drop.init_done", 32'(init_done), 32'd0);
        chk("drop.data_hold", 32'(data_out), 32'hA0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fc_rx_credit_buffer.md
Name: fc_rx_credit_buffer

Overview:
Receiver-side PCIe transaction-layer flow-control block for a single credit type. It buffers incoming TLP words, one word per credit, and tracks CREDITS_RECEIVED and CREDITS_ALLOCATED. It advertises the credit limit to the link partner as InitFC during link init and as UpdateFC as credits are freed. It is the far-end counterpart of the transmitter's pending buffer and credit-consumed counter.

Parameters:
DATA_WIDTH, 8, width of one buffered word (one credit)
FIFO_DEPTH, 16, receive buffer entries = credits initially advertised; power of 2, <= 2^(CREDIT_WIDTH-1)
CREDIT_WIDTH, 8, width of credit counters; all credit arithmetic is modulo 2^CREDIT_WIDTH
INIT_REPEATS, 2, number of acknowledged InitFC transfers before entering RUN
UPDATE_PERIOD, 32, cycles between forced UpdateFC resends (only with FC_UPDATE_TIMER_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
link_up  in  1  data link layer up; low = flush and stay idle
tlp_valid  in  1  incoming TLP word valid (no backpressure)
tlp_data  in  DATA_WIDTH  incoming word
rd_en  in  1  consumer pop request
data_out  out  DATA_WIDTH  popped word, registered
empty  out  1  buffer empty
fc_valid  out  1  FC DLLP request
fc_type  out  1  0 = InitFC, 1 = UpdateFC
fc_credit_limit  out  CREDIT_WIDTH  advertised limit (CREDITS_ALLOCATED snapshot)
fc_ack  in  1  DLL accepts FC DLLP
credits_received  out  CREDIT_WIDTH  CREDITS_RECEIVED counter
credits_allocated  out  CREDIT_WIDTH  CREDITS_ALLOCATED counter
init_done  out  1  high in RUN
overflow_err  out  1  sticky receiver overflow

Behaviour:
- Reset: all outputs 0, empty = 1, state IDLE, pointers and count 0, FIFO contents don't-care.
- FSM IDLE -> INIT when link_up = 1.
- INIT: credits_allocated loaded with FIFO_DEPTH on entry. fc_valid = 1, fc_type = 0, limit = FIFO_DEPTH. After INIT_REPEATS fc_valid && fc_ack transfers -> RUN.
- RUN: init_done = 1.
- link_up = 0 in any state -> IDLE next cycle. Pointers, count, credit counters, fc_valid and init_done clear; overflow_err clears; data_out holds.
- Handshake: fc_type and fc_credit_limit are held stable while fc_valid && !fc_ack. A transfer occurs on the cycle fc_valid && fc_ack. fc_valid is low for at least the following cycle.
- Writes, RUN only: tlp_valid with count < FIFO_DEPTH (pre-cycle count) -> store word, wr_ptr+1, credits_received+1.
- Write when count == FIFO_DEPTH -> word dropped, credits_received unchanged, overflow_err = 1. This applies even if a pop occurs in the same cycle.
- tlp_valid in IDLE or INIT is ignored and is not an overflow.
- Reads: rd_en && !empty -> data_out <= head word (1-cycle latency), rd_ptr+1, credits_allocated+1. rd_en when empty is a no-op; data_out holds.
- Simultaneous accepted write and pop: count unchanged, both counters increment.
- Pointers wrap at FIFO_DEPTH. Credit counters wrap at 2^CREDIT_WIDTH with no error.
- UpdateFC, RUN: a pop sets update_pending.
  - When update_pending && !fc_valid: assert fc_valid, fc_type = 1, limit = current credits_allocated snapshot, clear pending.
  - Pops during an outstanding request set pending again, giving exactly one further UpdateFC after the transfer.

Optional Feature:
FC_UPDATE_TIMER_EN.
- Defined: a counter reloads on every transfer and counts UPDATE_PERIOD cycles in RUN. On expiry with !fc_valid, an UpdateFC with the current credits_allocated is sent even if nothing was freed. If pending and the timer coincide, one DLLP is sent.
- Undefined: no timer logic; UpdateFC only on freed credits.

Test Plan:
- Reset with link_up = 0 -> all outputs 0, empty = 1. Raise link_up, ack each request -> two InitFC with limit 16, then init_done = 1, credits_allocated = 16.
- Write 16 words 0x00..0x0F -> credits_received = 16, no overflow. 17th word 0xAA -> dropped, overflow_err = 1, credits_received = 16.
- Pop 4 with fc_ack held low -> data_out 0x00..0x03 at 1-cycle latency; a single UpdateFC request with limit 17 stays stable until ack. After ack, a second UpdateFC with limit 20.
- Simultaneous write and pop at count 8 -> count stays 8, both counters +1. rd_en when empty -> data_out unchanged, credits_allocated unchanged.
- 250 write/pop pairs after init -> credits_received = 250, credits_allocated = (16 + 250) mod 256 = 10, no error.
- Drop link_up mid-RUN with 5 words buffered and a request outstanding -> next cycle IDLE, fc_valid = 0, counters 0, empty = 1. With FC_UPDATE_TIMER_EN defined and idle in RUN, UpdateFC with unchanged limit every 32 cycles after the last transfer.
